// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and instruction fetch front end.
// Single-entry buffer feeding the IF stage register, with branch redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        valid,
  output logic        fetch_busy
);

  localparam logic [1:0] REQ   = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic [31:0] tgt;
  logic [31:0] seq_pc;
  logic        xfer;

  assign tgt    = branch_addr & 32'hFFFF_FFFC;
  assign seq_pc = req_addr + 32'd4;
  assign xfer   = imem_req & imem_ready;

  assign imem_req    = (state == REQ) || (state == DRAIN);
  assign imem_addr   = req_addr;
  assign valid       = (state == FULL);
  assign Instruction = valid ? buf_instr : 32'h0;
  assign PC          = buf_pc;
  assign fetch_busy  = (state != FULL);

  // Fetch state machine: request, buffer, and discard-on-redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      buf_instr <= 32'h0;
      buf_pc    <= 32'h0;
    end else begin
      unique case (state)
        REQ: begin
          if (branch_taken) begin
            pc <= tgt;
            if (xfer) req_addr <= tgt;
            else      state    <= DRAIN;
          end else if (xfer) begin
            buf_instr <= imem_rdata;
            buf_pc    <= seq_pc;
            pc        <= seq_pc;
            state     <= FULL;
          end
        end
        DRAIN: begin
          if (xfer) begin
            state <= REQ;
            if (branch_taken) begin
              pc       <= tgt;
              req_addr <= tgt;
            end else begin
              req_addr <= pc;
            end
          end else if (branch_taken) begin
            pc <= tgt;
          end
        end
        FULL: begin
          if (branch_taken) begin
            pc       <= tgt;
            req_addr <= tgt;
            state    <= REQ;
          end else if (!freeze) begin
            req_addr <= pc;
            state    <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench with scoreboard of delivered fetches.
// Memory model returns an address-derived word, with one override slot.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        valid;
  logic        fetch_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] sp_addr = 32'hFFFF_FFFF;
  logic [31:0] sp_data = 32'h0;
  logic [63:0] sb[$];
  logic [63:0] ent;

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .PC(PC),
    .Instruction(Instruction),
    .valid(valid),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = (imem_addr == sp_addr) ? sp_data : mk(imem_addr);

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    logic [31:0] d;
    d = (a == sp_addr) ? sp_data : mk(a);
    sb.push_back({a + 32'd4, d});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: the buffer leaves on any edge it is consumed or flushed
  always @(negedge clk) begin
    if (rst && valid && (!freeze || branch_taken)) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        ent = sb.pop_front();
        chk("sb_pc", PC, ent[63:32]);
        chk("sb_instr", Instruction, ent[31:0]);
      end
    end
  end

  initial begin
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    imem_ready   = 1'b1;
    #12;
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd1);
    rst = 1'b1;

    // Zero-wait stream: one instruction every two cycles
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(i * 4);
      chk("seq_addr", imem_addr, a);
      chk("seq_req", {31'd0, imem_req}, 32'd1);
      chk("seq_bubble", Instruction, 32'h0);
      expect_fetch(a);
      tick;
      chk("seq_valid", {31'd0, valid}, 32'd1);
      chk("seq_pc", PC, a + 32'd4);
      chk("seq_noreq", {31'd0, imem_req}, 32'd0);
      if (i < 2) tick;
    end

    // Redirect from FULL to 0x200, then 3 wait cycles
    imem_ready   = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    tick;
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h200);
      chk("wait_busy", {31'd0, fetch_busy}, 32'd1);
      chk("wait_valid", {31'd0, valid}, 32'd0);
      tick;
    end
    imem_ready = 1'b1;
    chk("wait_addr4", imem_addr, 32'h200);
    expect_fetch(32'h200);
    tick;
    chk("wait_done", {31'd0, valid}, 32'd1);
    chk("wait_pc", PC, 32'h204);

    // Freeze holds the buffered 0xDEADBEEF
    sp_addr = 32'h204;
    sp_data = 32'hDEAD_BEEF;
    tick;
    expect_fetch(32'h204);
    tick;
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("frz_instr", Instruction, 32'hDEAD_BEEF);
      chk("frz_pc", PC, 32'h208);
      chk("frz_valid", {31'd0, valid}, 32'd1);
      chk("frz_req", {31'd0, imem_req}, 32'd0);
      tick;
    end
    freeze = 1'b0;
    tick;
    chk("frz_next", imem_addr, 32'h208);

    // Branch while fetch of 0x20C waits: that data is dropped
    expect_fetch(32'h208);
    tick;
    imem_ready = 1'b0;
    tick;
    chk("drn_addr0", imem_addr, 32'h20C);
    branch_taken = 1'b1;
    branch_addr  = 32'h400;
    tick;
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drn_hold", imem_addr, 32'h20C);
      chk("drn_valid", {31'd0, valid}, 32'd0);
      tick;
    end
    imem_ready = 1'b1;
    tick;
    chk("drn_novalid", {31'd0, valid}, 32'd0);
    chk("drn_tgt", imem_addr, 32'h400);
    expect_fetch(32'h400);
    tick;
    chk("drn_pc", PC, 32'h404);

    // Branch beats freeze in FULL; last of two DRAIN redirects wins
    freeze       = 1'b1;
    imem_ready   = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h500;
    tick;
    freeze = 1'b0;
    chk("bf_valid", {31'd0, valid}, 32'd0);
    chk("bf_addr", imem_addr, 32'h500);
    branch_addr = 32'h600;
    tick;
    branch_addr = 32'h703;
    tick;
    branch_taken = 1'b0;
    chk("bb_hold", imem_addr, 32'h500);
    chk("bb_busy", {31'd0, fetch_busy}, 32'd1);
    imem_ready = 1'b1;
    tick;
    chk("bb_last", imem_addr, 32'h700);
    expect_fetch(32'h700);
    tick;
    chk("bb_pc", PC, 32'h704);

    // Wrap at the top of the address space
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    tick;
    branch_taken = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC);
    tick;
    chk("wr_pc", PC, 32'h0);
    tick;
    chk("wr_next", imem_addr, 32'h0);

    // Reset in the middle of a wait
    imem_ready = 1'b0;
    tick;
    #2;
    rst = 1'b0;
    #1;
    chk("mr_addr", imem_addr, 32'h100);
    chk("mr_pc", PC, 32'h0);
    chk("mr_valid", {31'd0, valid}, 32'd0);
    chk("mr_busy", {31'd0, fetch_busy}, 32'd1);
    chk("mr_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst        = 1'b1;
    imem_ready = 1'b1;
    expect_fetch(32'h100);
    tick;
    chk("mr_pc2", PC, 32'h104);
    #6;
    freeze     = 1'b1;
    imem_ready = 1'b0;
    tick;
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
